// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite codes, data-phase state encoding and byte-lane helpers for ahb_sram_slave.
// Pure declarations: no logic, no latency.
// Backpressure: n/a. The D_WAIT state exists only when AHB_SRAM_WAIT_EN is defined.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_8  = 3'd0;
    localparam logic [2:0] HSIZE_16 = 3'd1;
    localparam logic [2:0] HSIZE_32 = 3'd2;
    localparam logic [2:0] HSIZE_64 = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        D_IDLE  = 3'd0,
        D_READ  = 3'd1,
        D_WRITE = 3'd2,
        D_ERR1  = 3'd3,
        D_ERR2  = 3'd4
`ifdef AHB_SRAM_WAIT_EN
        ,
        D_WAIT  = 3'd5
`endif
    } dstate_e;

    // Byte-lane enables for a legal (size <= 3) transfer starting at byte offset lo.
    function automatic logic [7:0] size_be(input logic [2:0] size, input logic [2:0] lo);
        logic [7:0] m;
        case (size)
            HSIZE_8:  m = 8'h01;
            HSIZE_16: m = 8'h03;
            HSIZE_32: m = 8'h0F;
            default:  m = 8'hFF;
        endcase
        return m << lo;
    endfunction

    // True when the low address bits are not aligned to the transfer size.
    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lo);
        logic r;
        case (size)
            HSIZE_16: r = lo[0];
            HSIZE_32: r = |lo[1:0];
            HSIZE_64: r = |lo;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // Overlay the enabled bytes of 'over' onto 'base'.
    function automatic logic [63:0] merge_bytes(input logic [63:0] base, input logic [63:0] over,
                                                input logic [7:0] be);
        logic [63:0] r;
        r = base;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[i*8 +: 8] = over[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle between the bus fabric/master and ahb_sram_slave.
// Wires only, no latency.
// Backpressure: hready from the slave, hready_in is the fabric-level ready.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [63:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [63:0] hwdata;
    logic        hready_in;
    logic        hready;
    logic        hresp;
    logic [63:0] hrdata;

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready_in,
        output hready, hresp, hrdata
    );

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata, hready_in,
        input  hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted write buffer with drain handshake and read-forwarding byte merge.
// Latency: capture lands the cycle after cap_vld; fwd_dat is combinational.
// Backpressure: holds its entry until drain_rdy; a capture in the drain cycle refills it.
module ahb_sram_wbuf
    import ahb_sram_slave_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_vld,
    input  logic [AW-1:0] cap_addr,
    input  logic [7:0]    cap_be,
    input  logic [63:0]   cap_dat,
    output logic          drain_vld,
    input  logic          drain_rdy,
    output logic [AW-1:0] drain_addr,
    output logic [7:0]    drain_be,
    output logic [63:0]   drain_dat,
    input  logic [AW-1:0] rd_addr,
    input  logic [63:0]   rd_dat,
    output logic [63:0]   fwd_dat
);

    logic          vld_q, vld_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    be_q, be_d;
    logic [63:0]   dat_q, dat_d;

    // Next entry: a new capture wins, otherwise the entry empties once drained.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        be_d   = be_q;
        dat_d  = dat_q;
        if (cap_vld) begin
            vld_d  = 1'b1;
            addr_d = cap_addr;
            be_d   = cap_be;
            dat_d  = cap_dat;
        end else if (vld_q && drain_rdy) begin
            vld_d  = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
            be_q   <= '0;
            dat_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            be_q   <= be_d;
            dat_q  <= dat_d;
        end
    end

    // Forward buffered bytes over SRAM read data when the dword matches.
    always_comb begin
        fwd_dat = rd_dat;
        if (vld_q && (addr_q == rd_addr)) fwd_dat = merge_bytes(rd_dat, dat_q, be_q);
    end

    assign drain_vld  = vld_q;
    assign drain_addr = addr_q;
    assign drain_be   = be_q;
    assign drain_dat  = dat_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder; zero-wait reads/writes via posted write buffer (AHB_SRAM_WAIT_EN adds read wait states).
// Latency: read data the cycle after the address phase; writes posted, drained when the SRAM port is free.
// Backpressure: one hready=0 cycle only when a read meets a write data phase with the buffer still full.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int          MEM_AW      = 13,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    ahb_sram_slave_if.slave   bus,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [7:0]        sram_be,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    localparam logic [63:0] MEM_BYTES = 64'd8 << MEM_AW;

    dstate_e           state_q, state_d;
    logic [MEM_AW-1:0] daddr_q, daddr_d;
    logic [7:0]        be_q, be_d;

    logic [63:0]       off;
    logic              acc, addr_err, stall, rd_issue, cap_vld;
    logic              hready_o, hresp_o;
    logic [63:0]       hrdata_o;
    logic              wb_vld, wb_rdy;
    logic [MEM_AW-1:0] wb_addr;
    logic [7:0]        wb_be;
    logic [63:0]       wb_dat, fwd_dat;

`ifdef AHB_SRAM_WAIT_EN
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   rdata_q, rdata_d;
`else
    logic unused_wait;
    assign unused_wait = (WAIT_CYCLES > 0);
`endif

    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock};

    // Address-phase decode: accept, window/size/alignment error.
    always_comb begin
        off      = bus.haddr - BASE_ADDR;
        acc      = bus.hsel && bus.hready_in && bus.htrans[1];
        addr_err = (off >= MEM_BYTES) || (bus.hsize > HSIZE_64) || misaligned(bus.hsize, bus.haddr[2:0]);
    end

    // Response from the data-phase state; a read colliding with a full buffer stalls the write.
    always_comb begin
        stall    = (state_q == D_WRITE) && wb_vld && bus.hsel && bus.htrans[1] && !bus.hwrite;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        case (state_q)
            D_ERR1:  begin hready_o = 1'b0; hresp_o = HRESP_ERROR; end
            D_ERR2:  hresp_o = HRESP_ERROR;
            D_WRITE: hready_o = !stall;
`ifdef AHB_SRAM_WAIT_EN
            D_WAIT:  hready_o = 1'b0;
`endif
            default: ;
        endcase
    end

    // SRAM port: read issue first, otherwise the buffer drains; nothing moves while in reset.
    always_comb begin
        rd_issue   = rst && acc && hready_o && !bus.hwrite && !addr_err;
        wb_rdy     = rst && !rd_issue;
        cap_vld    = rst && (state_q == D_WRITE) && hready_o;
        sram_cs    = rd_issue || (wb_vld && wb_rdy);
        sram_we    = wb_vld && wb_rdy;
        sram_addr  = rd_issue ? off[MEM_AW+2:3] : wb_addr;
        sram_be    = rd_issue ? 8'hFF : wb_be;
        sram_wdata = wb_dat;
    end

    // Data-phase FSM next state and captured beat attributes.
    always_comb begin
        state_d = state_q;
        daddr_d = daddr_q;
        be_d    = be_q;
`ifdef AHB_SRAM_WAIT_EN
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`endif
        case (state_q)
            D_ERR1: state_d = D_ERR2;
`ifdef AHB_SRAM_WAIT_EN
            D_WAIT: begin
                if (cnt_q == CW'(WAIT_CYCLES)) rdata_d = fwd_dat;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = D_READ;
            end
`endif
            default: begin
                if (hready_o) begin
                    if (acc) begin
                        daddr_d = off[MEM_AW+2:3];
                        be_d    = size_be(bus.hsize, bus.haddr[2:0]);
                        if (addr_err) begin
                            state_d = D_ERR1;
                        end else if (bus.hwrite) begin
                            state_d = D_WRITE;
                        end else begin
`ifdef AHB_SRAM_WAIT_EN
                            state_d = D_WAIT;
                            cnt_d   = CW'(WAIT_CYCLES);
`else
                            state_d = D_READ;
`endif
                        end
                    end else begin
                        state_d = D_IDLE;
                    end
                end
            end
        endcase
    end

    // FSM state and beat registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= D_IDLE;
            daddr_q <= '0;
            be_q    <= '0;
`ifdef AHB_SRAM_WAIT_EN
            cnt_q   <= '0;
            rdata_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            daddr_q <= daddr_d;
            be_q    <= be_d;
`ifdef AHB_SRAM_WAIT_EN
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`endif
        end
    end

    // Read data is driven only during a read data phase.
    always_comb begin
        hrdata_o = '0;
`ifdef AHB_SRAM_WAIT_EN
        if (state_q == D_READ) hrdata_o = rdata_q;
`else
        if (state_q == D_READ) hrdata_o = fwd_dat;
`endif
    end

    assign bus.hready = hready_o;
    assign bus.hresp  = hresp_o;
    assign bus.hrdata = hrdata_o;

    ahb_sram_wbuf #(.AW(MEM_AW)) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .cap_vld    (cap_vld),
        .cap_addr   (daddr_q),
        .cap_be     (be_q),
        .cap_dat    (bus.hwdata),
        .drain_vld  (wb_vld),
        .drain_rdy  (wb_rdy),
        .drain_addr (wb_addr),
        .drain_be   (wb_be),
        .drain_dat  (wb_dat),
        .rd_addr    (daddr_q),
        .rd_dat     (sram_rdata),
        .fwd_dat    (fwd_dat)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave (default build) with a behavioural 1-cycle SRAM.
// Inputs change 1ns after posedge, outputs are sampled on negedge.
// Backpressure: hready_in is tied to the slave hready.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam logic [63:0] VA = 64'hA0A1_A2A3_A4A5_A6A7;
    localparam logic [63:0] VB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [63:0] VC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [63:0] VD = 64'hD0D1_D2D3_D4D5_D6D7;
    localparam logic [63:0] VE = 64'hE0E1_E2E3_E4E5_E6E7;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_be;
    logic [12:0] sram_addr;
    logic [63:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic [63:0] mem [0:8191];

    int checks = 0;
    int errors = 0;

    ahb_sram_slave_if bus_if ();
    assign bus_if.hready_in = bus_if.hready;

    ahb_sram_slave dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte-enable writes, registered read data.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
            mem[2] <= VC;
            mem[3] <= VD;
            sram_rdata <= '0;
        end else if (sram_cs) begin
            if (sram_we) begin
                for (int i = 0; i < 8; i++)
                    if (sram_be[i]) mem[sram_addr][i*8 +: 8] <= sram_wdata[i*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [63:0] addr);
        bus_if.hsel   = sel;
        bus_if.htrans = trans;
        bus_if.hwrite = wr;
        bus_if.hsize  = size;
        bus_if.haddr  = addr;
    endtask

    task automatic idle();
        drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_8, 64'h0);
        bus_if.hburst = 3'b000;
    endtask

    initial begin
        rst = 1'b0;
        mem_init = 1'b1;
        idle();
        bus_if.hprot = 4'h3;
        bus_if.hmastlock = 1'b0;
        bus_if.hwdata = '0;
        tick(); tick();
        smp();
        chk("rst_hready", bus_if.hready, 1);
        chk("rst_hresp",  bus_if.hresp, 0);
        chk("rst_hrdata", bus_if.hrdata, 0);
        chk("rst_cs",     sram_cs, 0);
        tick();
        rst = 1'b1;
        mem_init = 1'b0;

        // 1: write then read the same dword
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0000);
        smp(); chk("t1_w_hready", bus_if.hready, 1); tick();
        bus_if.hwdata = 64'h1122_3344_5566_7788;
        drive(1, HTRANS_NONSEQ, 0, HSIZE_64, 64'h8000_0000);
        smp(); chk("t1_wd_hready", bus_if.hready, 1); chk("t1_rd_cs", sram_cs, 1); chk("t1_rd_we", sram_we, 0); tick();
        idle();
        smp(); chk("t1_hrdata", bus_if.hrdata, 64'h1122_3344_5566_7788); chk("t1_hresp", bus_if.hresp, 0);
        chk("t1_r_hready", bus_if.hready, 1); chk("t1_drain_we", sram_we, 1); tick();
        smp(); chk("t1_idle_hrdata", bus_if.hrdata, 0); chk("t1_mem0", mem[0], 64'h1122_3344_5566_7788);
        chk("t1_idle_cs", sram_cs, 0); tick();

        // 2: write all-F then immediate read of it, served by forwarding
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0008); tick();
        bus_if.hwdata = '1;
        drive(1, HTRANS_NONSEQ, 0, HSIZE_64, 64'h8000_0008); tick();
        idle();
        smp(); chk("t2_hrdata", bus_if.hrdata, 64'hFFFF_FFFF_FFFF_FFFF); chk("t2_drain_we", sram_we, 1);
        chk("t2_drain_addr", sram_addr, 1); tick();
        smp(); chk("t2_mem1", mem[1], 64'hFFFF_FFFF_FFFF_FFFF); tick();

        // 3: W, W, R -> one stall cycle in the second write's data phase
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0000);
        smp(); chk("t3_c0_hready", bus_if.hready, 1); tick();
        bus_if.hwdata = VA;
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0008);
        smp(); chk("t3_c1_hready", bus_if.hready, 1); tick();
        bus_if.hwdata = VB;
        drive(1, HTRANS_NONSEQ, 0, HSIZE_64, 64'h8000_0010);
        smp(); chk("t3_stall_hready", bus_if.hready, 0); chk("t3_stall_we", sram_we, 1);
        chk("t3_stall_addr", sram_addr, 0); tick();
        smp(); chk("t3_c3_hready", bus_if.hready, 1); chk("t3_rd_cs", sram_cs, 1); chk("t3_rd_we", sram_we, 0); tick();
        idle();
        smp(); chk("t3_hrdata", bus_if.hrdata, VC); chk("t3_c4_hready", bus_if.hready, 1); tick();
        smp(); chk("t3_mem0", mem[0], VA); chk("t3_mem1", mem[1], VB); tick();

        // 4: misaligned word read, then out-of-range write
        drive(1, HTRANS_NONSEQ, 0, HSIZE_32, 64'h8000_0002);
        smp(); chk("t4_a_cs", sram_cs, 0); tick();
        idle();
        smp(); chk("t4_e1_hready", bus_if.hready, 0); chk("t4_e1_hresp", bus_if.hresp, 1); chk("t4_e1_cs", sram_cs, 0); tick();
        smp(); chk("t4_e2_hready", bus_if.hready, 1); chk("t4_e2_hresp", bus_if.hresp, 1); tick();
        smp(); chk("t4_after_hresp", bus_if.hresp, 0); tick();
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8001_0000); tick();
        bus_if.hwdata = 64'hDEAD_BEEF_DEAD_BEEF;
        idle();
        smp(); chk("t4_oor_hready", bus_if.hready, 0); chk("t4_oor_hresp", bus_if.hresp, 1); tick();
        smp(); chk("t4_oor_e2_hresp", bus_if.hresp, 1); tick();
        smp(); chk("t4_oor_cs", sram_cs, 0); tick();

        // 5: INCR4 read burst with a BUSY beat
        bus_if.hburst = 3'b011;
        drive(1, HTRANS_NONSEQ, 0, HSIZE_64, 64'h8000_0000);
        smp(); chk("t5_b0_cs", sram_cs, 1); tick();
        drive(1, HTRANS_SEQ, 0, HSIZE_64, 64'h8000_0008);
        smp(); chk("t5_d0", bus_if.hrdata, VA); tick();
        drive(1, HTRANS_BUSY, 0, HSIZE_64, 64'h8000_0010);
        smp(); chk("t5_d1", bus_if.hrdata, VB); chk("t5_busy_cs", sram_cs, 0); tick();
        drive(1, HTRANS_SEQ, 0, HSIZE_64, 64'h8000_0010);
        smp(); chk("t5_busy_hresp", bus_if.hresp, 0); chk("t5_busy_hready", bus_if.hready, 1);
        chk("t5_busy_hrdata", bus_if.hrdata, 0); tick();
        drive(1, HTRANS_SEQ, 0, HSIZE_64, 64'h8000_0018);
        smp(); chk("t5_d2", bus_if.hrdata, VC); tick();
        idle();
        smp(); chk("t5_d3", bus_if.hrdata, VD); tick();

        // 7: byte write into lane 3 forwarded into a full dword read
        drive(1, HTRANS_NONSEQ, 1, HSIZE_8, 64'h8000_0003); tick();
        bus_if.hwdata = 64'hFFFF_FFFF_5AFF_FFFF;
        drive(1, HTRANS_NONSEQ, 0, HSIZE_64, 64'h8000_0000); tick();
        idle();
        smp(); chk("t7_hrdata", bus_if.hrdata, 64'hA0A1_A2A3_5AA5_A6A7); chk("t7_drain_be", sram_be, 8'h08); tick();
        smp(); chk("t7_mem0", mem[0], 64'hA0A1_A2A3_5AA5_A6A7); tick();

        // 6: reset while a write data phase has the buffer full
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0020); tick();
        bus_if.hwdata = VE;
        drive(1, HTRANS_NONSEQ, 1, HSIZE_64, 64'h8000_0028);
        smp(); chk("t6_w_hready", bus_if.hready, 1); tick();
        bus_if.hwdata = 64'h0F0F_0F0F_0F0F_0F0F;
        idle();
        rst = 1'b0;
        smp(); chk("t6_inrst_cs", sram_cs, 0); tick();
        rst = 1'b1;
        smp(); chk("t6_hready", bus_if.hready, 1); chk("t6_hresp", bus_if.hresp, 0);
        chk("t6_cs", sram_cs, 0); chk("t6_hrdata", bus_if.hrdata, 0); tick();
        smp(); chk("t6_mem4", mem[4], 0); chk("t6_mem5", mem[5], 0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
